// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared button indices, default timing and width helper
package button_conditioner_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int NUM_BTNS  = 5;

  localparam int DEBOUNCE_CYCLES_DEF = 650000;
  localparam int LOCK_FRAMES_DEF     = 600;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - 2-flop synchroniser plus stable-count debouncer for one raw button
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic clean
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample that agrees with the clean level restarts the count
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced directions, enter strobe and move_en toggle
// Optional idle timeout on move_en under MOVE_LOCK_TIMEOUT_EN.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20,
  parameter int LOCK_FRAMES     = LOCK_FRAMES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_enter,
  input  logic vsync,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic enter_pulse,
  output logic move_en
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] clean;

  assign btn_raw[BTN_UP]    = btn_up;
  assign btn_raw[BTN_DOWN]  = btn_down;
  assign btn_raw[BTN_LEFT]  = btn_left;
  assign btn_raw[BTN_RIGHT] = btn_right;
  assign btn_raw[BTN_ENTER] = btn_enter;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .clean(clean[i])
    );
  end

  logic enter_prev_q, enter_prev_d;
  logic enter_pulse_q, enter_pulse_d;
  logic move_en_q, move_en_d;
  logic enter_rise;

`ifdef MOVE_LOCK_TIMEOUT_EN
  localparam int IDLE_W = clog2(LOCK_FRAMES + 1);
  logic              vsync_q, vsync_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              vsync_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      idle_q  <= '0;
    end else begin
      vsync_q <= vsync_d;
      idle_q  <= idle_d;
    end
  end
`else
  localparam int unused_lock_frames = LOCK_FRAMES;
  logic unused_vsync;
  assign unused_vsync = vsync;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      enter_prev_q  <= 1'b0;
      enter_pulse_q <= 1'b0;
      move_en_q     <= 1'b0;
    end else begin
      enter_prev_q  <= enter_prev_d;
      enter_pulse_q <= enter_pulse_d;
      move_en_q     <= move_en_d;
    end
  end

  always_comb begin
    enter_rise    = clean[BTN_ENTER] & ~enter_prev_q;
    enter_prev_d  = clean[BTN_ENTER];
    enter_pulse_d = enter_rise;
    move_en_d     = move_en_q ^ enter_rise;
`ifdef MOVE_LOCK_TIMEOUT_EN
    vsync_d    = vsync;
    vsync_fall = vsync_q & ~vsync;
    idle_d     = idle_q;
    // An enter toggle outranks a timeout landing on the same edge
    if (enter_rise || !move_en_q || (|clean[BTN_RIGHT:BTN_UP])) begin
      idle_d = '0;
    end else if (vsync_fall) begin
      if (idle_q == IDLE_W'(LOCK_FRAMES - 1)) begin
        move_en_d = 1'b0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  assign up          = clean[BTN_UP];
  assign down        = clean[BTN_DOWN];
  assign left        = clean[BTN_LEFT];
  assign right       = clean[BTN_RIGHT];
  assign enter_pulse = enter_pulse_q;
  assign move_en     = move_en_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized bench against a stable-window reference model
module tb_button_conditioner;

  localparam int DC   = 4;
  localparam int LF   = 3;
  localparam int MAXC = 8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_enter = 1'b0;
  logic vsync = 1'b0;
  logic up, down, left, right, enter_pulse, move_en;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3),
    .LOCK_FRAMES    (LF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_enter  (btn_enter),
    .vsync      (vsync),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .enter_pulse(enter_pulse),
    .move_en    (move_en)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model history indexed by clock edge: raw[k] is what the bench drove before edge k
  logic [4:0] raw    [0:MAXC];
  logic       vs_raw [0:MAXC];
  logic [4:0] mclean [0:MAXC];
  logic       mpulse, mmove;
  int         midle, k, last_rst, lat, cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // A clean level flips once the synchronised value has disagreed with it
  // on each of the last DC edges since the most recent reset.
  task automatic apply(input logic r, input logic [4:0] b, input logic v);
    logic rise, flip, sb, c, pmove;
    {btn_enter, btn_right, btn_left, btn_down, btn_up} = b;
    rst   = r;
    vsync = v;
    k++;
    if (k >= MAXC) begin
      $display("FAIL model_overflow: got %0d expected below %0d", k, MAXC);
      $fatal(1);
    end
    raw[k]    = b;
    vs_raw[k] = v;
    if (r) begin
      last_rst  = k;
      mclean[k] = '0;
      mpulse    = 1'b0;
      mmove     = 1'b0;
      midle     = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        c    = mclean[k-1][i];
        flip = 1'b1;
        for (int j = k - DC + 1; j <= k; j++) begin
          if (j <= last_rst) flip = 1'b0;
          else begin
            sb = (j - 2 > last_rst) ? raw[j-2][i] : 1'b0;
            if (sb == c) flip = 1'b0;
          end
        end
        mclean[k][i] = flip ? ~c : c;
      end
      rise   = mclean[k-1][4] & ~mclean[k-2][4];
      pmove  = mmove;
      mpulse = rise;
      if (rise) mmove = ~mmove;
`ifdef MOVE_LOCK_TIMEOUT_EN
      if (rise || !pmove || (|mclean[k-1][3:0])) midle = 0;
      else if ((k - 1 > last_rst) && vs_raw[k-1] && !vs_raw[k]) begin
        if (midle == LF - 1) begin
          mmove = 1'b0;
          midle = 0;
        end else midle++;
      end
`else
      pmove = pmove;
`endif
    end
  endtask

  task automatic cycle(input logic r, input logic [4:0] b, input logic v);
    @(negedge clk);
    chk("up",          up,          mclean[k][0]);
    chk("down",        down,        mclean[k][1]);
    chk("left",        left,        mclean[k][2]);
    chk("right",       right,       mclean[k][3]);
    chk("enter_pulse", enter_pulse, mpulse);
    chk("move_en",     move_en,     mmove);
    apply(r, b, v);
  endtask

  initial begin
    logic [4:0] b;
    logic       v;
    k         = 1;
    last_rst  = 1;
    raw[0]    = '0; raw[1]    = '0;
    vs_raw[0] = 1'b0; vs_raw[1] = 1'b0;
    mclean[0] = '0; mclean[1] = '0;
    mpulse    = 1'b0;
    mmove     = 1'b0;
    midle     = 0;
    apply(1'b1, 5'b0, 1'b0);
    cycle(1'b1, 5'b0, 1'b0);

    // Press latency on up
    cycle(1'b0, 5'b00001, 1'b0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle(1'b0, 5'b00001, 1'b0);
      if (up === 1'b1 && lat == 0) lat = n;
    end
    chk("up_latency", lat, 6);
    repeat (10) cycle(1'b0, 5'b0, 1'b0);

    // Glitched left press: latency counts from the final 0->1
    repeat (3) cycle(1'b0, 5'b00100, 1'b0);
    cycle(1'b0, 5'b0, 1'b0);
    cycle(1'b0, 5'b00100, 1'b0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle(1'b0, 5'b00100, 1'b0);
      if (left === 1'b1 && lat == 0) lat = n;
    end
    chk("left_glitch_latency", lat, 6);
    repeat (10) cycle(1'b0, 5'b0, 1'b0);

    // Long enter hold gives a single toggle; release gives none
    cnt = 0;
    for (int n = 0; n < 50; n++) begin
      cycle(1'b0, 5'b10000, 1'b0);
      cnt += int'(enter_pulse);
    end
    for (int n = 0; n < 20; n++) begin
      cycle(1'b0, 5'b0, 1'b0);
      cnt += int'(enter_pulse);
    end
    chk("enter_pulse_count", cnt, 1);
    chk("move_en_first_press", move_en, 1);
    repeat (30) cycle(1'b0, 5'b10000, 1'b0);
    repeat (20) cycle(1'b0, 5'b0, 1'b0);
    chk("move_en_second_press", move_en, 0);

    // Reset while right's count is at 2 discards the partial count
    repeat (4) cycle(1'b0, 5'b01000, 1'b0);
    cycle(1'b1, 5'b01000, 1'b0);
    cycle(1'b0, 5'b01000, 1'b0);
    chk("right_after_reset", right, 0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle(1'b0, 5'b01000, 1'b0);
      if (right === 1'b1 && lat == 0) lat = n;
    end
    chk("right_latency_after_reset", lat, 6);
    repeat (10) cycle(1'b0, 5'b0, 1'b0);

`ifdef MOVE_LOCK_TIMEOUT_EN
    repeat (15) cycle(1'b0, 5'b10000, 1'b0);
    repeat (10) cycle(1'b0, 5'b0, 1'b0);
    chk("move_en_before_idle", move_en, 1);
    for (int f = 0; f < 3; f++) begin
      repeat (4) cycle(1'b0, 5'b0, 1'b1);
      repeat (4) cycle(1'b0, 5'b0, 1'b0);
    end
    chk("idle_timeout_clear", move_en, 0);
`endif

    // Randomized slowly-changing buttons with occasional glitches and resets
    b = '0;
    v = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
      if ($urandom_range(0, 2) == 0) v = ~v;
      cycle(($urandom_range(0, 299) == 0), b, v);
    end
    cycle(1'b0, 5'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
